conv_icb_master: RTL

- ICB initiator that drives the accelerator's ICB slave from the system side.
- Copies a block of words from a source region to a destination region using read-then-write pairs, then writes the start word to the control register.
- Then polls a status register until a done bit is set, or until a timeout.
- Sits between the host/test controller and the conv accelerator's ICB slave port. Keeps exactly one ICB transaction outstanding at any time.

---
 rtl/conv_icb_master_if.sv | 34 +++
 rtl/conv_icb_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_icb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_icb_master_if
//  Description : ICB command/response bundle between initiator and slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_icb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    icb_cmd_valid;
    logic                    icb_cmd_ready;
    logic                    icb_cmd_read;
    logic [ADDR_WIDTH-1:0]   icb_cmd_addr;
    logic [DATA_WIDTH-1:0]   icb_cmd_wdata;
    logic [DATA_WIDTH/8-1:0] icb_cmd_wmask;
    logic                    icb_rsp_valid;
    logic                    icb_rsp_ready;
    logic [DATA_WIDTH-1:0]   icb_rsp_rdata;
    logic                    icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/conv_icb_master.sv
`default_nettype none
// ============================================================================
//  Module      : conv_icb_master
//  Description : ICB initiator: block copy, control write, then status poll.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_icb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int POLL_MAX   = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] src_addr,
    input  wire logic [ADDR_WIDTH-1:0] dst_addr,
    input  wire logic [LEN_WIDTH-1:0]  len,
    input  wire logic [ADDR_WIDTH-1:0] ctrl_addr,
    input  wire logic [DATA_WIDTH-1:0] ctrl_wdata,
    input  wire logic [ADDR_WIDTH-1:0] stat_addr,
    input  wire logic [DATA_WIDTH-1:0] stat_mask,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    conv_icb_master_if.master          icb
);
    localparam int c_MW = DATA_WIDTH / 8;
    localparam int c_PW = $clog2(POLL_MAX + 1);
    localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_MAX - 1);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_RD_CMD   = 4'd1;
    localparam logic [3:0] c_ST_RD_RSP   = 4'd2;
    localparam logic [3:0] c_ST_WR_CMD   = 4'd3;
    localparam logic [3:0] c_ST_WR_RSP   = 4'd4;
    localparam logic [3:0] c_ST_GO_CMD   = 4'd5;
    localparam logic [3:0] c_ST_GO_RSP   = 4'd6;
    localparam logic [3:0] c_ST_POLL_CMD = 4'd7;
    localparam logic [3:0] c_ST_POLL_RSP = 4'd8;
    localparam logic [3:0] c_ST_DONE     = 4'd9;
    localparam logic [3:0] c_ST_ERR      = 4'd10;

    logic [3:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [c_PW-1:0]       r_poll_cnt;
    logic [ADDR_WIDTH-1:0] r_ctrl_addr;
    logic [DATA_WIDTH-1:0] r_ctrl_wdata;
    logic [ADDR_WIDTH-1:0] r_stat_addr;
    logic [DATA_WIDTH-1:0] r_stat_mask;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic                  r_cmd_valid;
    logic                  r_cmd_read;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;
    logic [c_MW-1:0]       r_cmd_wmask;
    logic                  r_rsp_ready;

    wire logic w_cmd_fire = r_cmd_valid && icb.icb_cmd_ready;
    wire logic w_rsp_fire = r_rsp_ready && icb.icb_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_poll_cnt   <= '0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
            r_stat_addr  <= '0;
            r_stat_mask  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
            r_cmd_valid  <= 1'b0;
            r_cmd_read   <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_wmask  <= '0;
            r_rsp_ready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_len        <= len;
                        r_ctrl_addr  <= ctrl_addr;
                        r_ctrl_wdata <= ctrl_wdata;
                        r_stat_addr  <= stat_addr;
                        r_stat_mask  <= stat_mask;
                        r_cnt        <= '0;
                        r_poll_cnt   <= '0;
                        r_err        <= 1'b0;
                        r_err_code   <= 2'b00;
                        r_busy       <= 1'b1;
                        r_cmd_valid  <= 1'b1;
                        // r_src_ptr always points at the next read to issue
                        r_src_ptr    <= src_addr + ADDR_WIDTH'(4);
                        r_dst_ptr    <= dst_addr;
                        if (len != '0) begin
                            r_state     <= c_ST_RD_CMD;
                            r_cmd_read  <= 1'b1;
                            r_cmd_addr  <= src_addr;
                            r_cmd_wmask <= '0;
                        end else begin
                            r_state     <= c_ST_GO_CMD;
                            r_cmd_read  <= 1'b0;
                            r_cmd_addr  <= ctrl_addr;
                            r_cmd_wdata <= ctrl_wdata;
                            r_cmd_wmask <= '1;
                        end
                    end
                end
                c_ST_RD_CMD, c_ST_WR_CMD, c_ST_GO_CMD, c_ST_POLL_CMD: begin
                    if (w_cmd_fire) begin
                        r_cmd_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_state     <= r_state + 4'd1;
                    end
                end
                c_ST_RD_RSP, c_ST_WR_RSP, c_ST_GO_RSP, c_ST_POLL_RSP: begin
                    if (w_rsp_fire) begin
                        r_rsp_ready <= 1'b0;
                        if (icb.icb_rsp_err) begin
                            r_state    <= c_ST_ERR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= (r_state == c_ST_RD_RSP || r_state == c_ST_WR_RSP) ? 2'b01 : 2'b10;
                        end else begin
                            case (r_state)
                                c_ST_RD_RSP: begin
                                    r_state     <= c_ST_WR_CMD;
                                    r_cmd_valid <= 1'b1;
                                    r_cmd_read  <= 1'b0;
                                    r_cmd_addr  <= r_dst_ptr;
                                    r_cmd_wdata <= icb.icb_rsp_rdata;
                                    r_cmd_wmask <= '1;
                                    r_dst_ptr   <= r_dst_ptr + ADDR_WIDTH'(4);
                                end
                                c_ST_WR_RSP: begin
                                    r_cnt       <= r_cnt + LEN_WIDTH'(1);
                                    r_cmd_valid <= 1'b1;
                                    if (r_cnt == r_len - LEN_WIDTH'(1)) begin
                                        r_state     <= c_ST_GO_CMD;
                                        r_cmd_read  <= 1'b0;
                                        r_cmd_addr  <= r_ctrl_addr;
                                        r_cmd_wdata <= r_ctrl_wdata;
                                        r_cmd_wmask <= '1;
                                    end else begin
                                        r_state     <= c_ST_RD_CMD;
                                        r_cmd_read  <= 1'b1;
                                        r_cmd_addr  <= r_src_ptr;
                                        r_cmd_wmask <= '0;
                                        r_src_ptr   <= r_src_ptr + ADDR_WIDTH'(4);
                                    end
                                end
                                c_ST_GO_RSP: begin
                                    r_state     <= c_ST_POLL_CMD;
                                    r_cmd_valid <= 1'b1;
                                    r_cmd_read  <= 1'b1;
                                    r_cmd_addr  <= r_stat_addr;
                                    r_cmd_wmask <= '0;
                                end
                                default: begin
                                    // status poll: a hit on the final permitted read still wins
                                    r_poll_cnt <= r_poll_cnt + c_PW'(1);
                                    if ((icb.icb_rsp_rdata & r_stat_mask) != '0) begin
                                        r_state <= c_ST_DONE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end else if (r_poll_cnt == c_POLL_LAST) begin
                                        r_state    <= c_ST_ERR;
                                        r_busy     <= 1'b0;
                                        r_err      <= 1'b1;
                                        r_err_code <= 2'b11;
                                    end else begin
                                        r_state     <= c_ST_POLL_CMD;
                                        r_cmd_valid <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                c_ST_ERR:  r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;
    assign err_code          = r_err_code;
    assign icb.icb_cmd_valid = r_cmd_valid;
    assign icb.icb_cmd_read  = r_cmd_read;
    assign icb.icb_cmd_addr  = r_cmd_addr;
    assign icb.icb_cmd_wdata = r_cmd_wdata;
    assign icb.icb_cmd_wmask = r_cmd_wmask;
    assign icb.icb_rsp_ready = r_rsp_ready;
endmodule
`default_nettype wire
